// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the uart_tx scheduler and its users:
//   - sched_state_e   : scheduler FSM encoding (IDLE / ISSUE / HOLD)
//   - FRAME_BITS      : start + 8 data + stop + one idle guard bit
//   - calc_bit_cycles : clocks per UART bit, identical to the uart_tx derivation
//   - rr_next         : modulo step used by the round-robin search
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } sched_state_e;

    localparam int FRAME_BITS = 11;

    function automatic int calc_bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud + 1;
    endfunction

    function automatic int rr_next(input int ptr, input int step, input int n);
        return (ptr + step) % n;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Bundles the requester handshake and the uart_tx-facing outputs of the scheduler.
//   req_valid  : per-requester byte pending
//   req_data   : byte of requester i at [8*i+7:8*i]
//   req_ready  : one-hot accept pulse
//   tx_data    : byte for uart_tx pi_data
//   tx_start   : one-cycle pulse for uart_tx pi_flag
//   gnt_id     : index of the most recent grant
//   busy       : high from grant until frame_done
//   frame_done : one-cycle pulse when the hold time expires
// Modports: master = client side, slave = scheduler side.
interface uart_tx_sched_if #(parameter int NUM_REQ = 4);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic [IDW-1:0]       gnt_id;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_start, gnt_id, busy, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_start, gnt_id, busy, frame_done
    );

endinterface

// File: rtl/uart_rr_arb.sv
// uart_rr_arb
// Combinational round-robin pick. Searches upward from ptr_i+1 (modulo NUM_REQ);
// the first requester with req_i set wins.
// Ports:
//   req_i     : request vector
//   ptr_i     : index of the previous winner
//   gnt_oh_o  : one-hot winner
//   gnt_idx_o : winner index
//   gnt_any_o : some requester won
// Config: UART_TX_SCHED_PRIO_EN makes requester 0 win whenever it requests.
module uart_rr_arb
    import uart_tx_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]     gnt_idx_o,
    output logic               gnt_any_o
);

    always_comb begin
        int idx;
        idx       = 0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
`ifdef UART_TX_SCHED_PRIO_EN
        if (req_i[0]) begin
            gnt_oh_o[0] = 1'b1;
            gnt_any_o   = 1'b1;
        end else
`endif
        begin
            // With priority enabled req_i[0] is clear here, so the loop
            // naturally rotates among requesters 1..NUM_REQ-1 only.
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = rr_next(int'(ptr_i), k, NUM_REQ);
                if (!gnt_any_o && req_i[idx]) begin
                    gnt_any_o     = 1'b1;
                    gnt_idx_o     = IDW'(idx);
                    gnt_oh_o[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one uart_tx between NUM_REQ byte requesters. A grant in IDLE is followed
// by a one-cycle tx_start/req_ready pulse (ISSUE), then HOLD blocks further grants
// until the 10-bit frame plus one idle guard bit has elapsed on the line.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-high reset
//   sched_if : uart_tx_sched_if.slave (requester handshake + uart_tx drive)
// Config: UART_TX_SCHED_PRIO_EN gives requester 0 strict priority; the
// round-robin pointer is left untouched by its grants.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CLK_FREQUENCE = 5_000_000,
    parameter int BAUD_RATE     = 9600
) (
    input logic               clk,
    input logic               rst,
    uart_tx_sched_if.slave    sched_if
);

    localparam int BIT_CYCLES   = calc_bit_cycles(CLK_FREQUENCE, BAUD_RATE);
    localparam int FRAME_CYCLES = FRAME_BITS * BIT_CYCLES;
    localparam int TW           = $clog2(FRAME_CYCLES);
    localparam int IDW          = $clog2(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gnt_q, gnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDW-1:0]     win_idx;
    logic               win_any;

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (sched_if.req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (win_oh),
        .gnt_idx_o (win_idx),
        .gnt_any_o (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDW'(NUM_REQ - 1);
            gnt_q     <= '0;
            tx_data_q <= '0;
            ready_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timer_q   <= timer_d;
        end
    end

    // Outputs are registered, so every pulse is set up one state ahead:
    // tx_start/req_ready on the grant edge, frame_done when the timer hits 1,
    // which lands it in the last HOLD cycle (timer 0).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        tx_data_d = tx_data_q;
        ready_d   = '0;
        start_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timer_d   = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (win_any) begin
                    state_d   = ST_ISSUE;
                    gnt_d     = win_idx;
                    tx_data_d = sched_if.req_data[8*win_idx +: 8];
`ifdef UART_TX_SCHED_PRIO_EN
                    if (win_idx != '0) begin
                        ptr_d = win_idx;
                    end
`else
                    ptr_d     = win_idx;
`endif
                    ready_d   = win_oh;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
                timer_d = TW'(FRAME_CYCLES - 2);
                busy_d  = 1'b1;
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (timer_q == TW'(1)) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sched_if.req_ready  = ready_q;
    assign sched_if.tx_start   = start_q;
    assign sched_if.tx_data    = tx_data_q;
    assign sched_if.gnt_id     = gnt_q;
    assign sched_if.busy       = busy_q;
    assign sched_if.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Directed + randomized bench for uart_tx_sched at CLK_FREQUENCE=100, BAUD_RATE=10
// (frame hold of 121 cycles). Expected grants come from a reference model that
// remembers the last winner and scans the valid vector in rotation order.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours UART_TX_SCHED_PRIO_EN in its model when the build defines it.
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int CLKF  = 100;
    localparam int BAUD  = 10;
    localparam int FRAME = 11 * (CLKF / BAUD + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_sched #(
        .NUM_REQ       (NREQ),
        .CLK_FREQUENCE (CLKF),
        .BAUD_RATE     (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         modelLast;
    logic [7:0] reqByte [NREQ];
    logic [7:0] lastData;

    // Watchdog so the bench can never hang on a stuck design.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v);
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = reqByte[i];
    endtask

    // Reference arbitration: starting just after the last winner, walk the
    // requesters in rotation and take the first that is asking.
    function automatic int modelPick(input logic [NREQ-1:0] v);
        int order [$];
`ifdef UART_TX_SCHED_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) order.push_back((modelLast + k) % NREQ);
        foreach (order[n]) if (v[order[n]]) return order[n];
        return -1;
    endfunction

    function automatic void modelCommit(input int w);
`ifdef UART_TX_SCHED_PRIO_EN
        if (w == 0) return;
`endif
        modelLast = w;
    endfunction

    task automatic awaitStart(input string tag, input int bound, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.tx_start !== 1'b1 && lat < bound);
        if (bus.tx_start !== 1'b1) checkOutput({tag, "_timeout"}, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic awaitIdle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) checkOutput({tag, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    // Called in the tx_start cycle: compare against the model, then the
    // granted requester refreshes its byte for the following request.
    task automatic checkGrant(input string tag, input logic [NREQ-1:0] v);
        int w;
        w = modelPick(v);
        checkOutput({tag, "_gnt"},   32'(bus.gnt_id),    32'(w));
        checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << w);
        checkOutput({tag, "_data"},  32'(bus.tx_data),   32'(reqByte[w]));
        checkOutput({tag, "_busy"},  32'(bus.busy),      32'd1);
        modelCommit(w);
        lastData   = reqByte[w];
        reqByte[w] = 8'($urandom);
    endtask

    initial begin
        int lat;
        int cnt;
        logic quiet;
        logic [NREQ-1:0] v;

        modelLast = NREQ - 1;
        for (int i = 0; i < NREQ; i++) reqByte[i] = 8'($urandom);
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready", 32'(bus.req_ready),  32'd0);
        checkOutput("rst_start", 32'(bus.tx_start),   32'd0);
        checkOutput("rst_data",  32'(bus.tx_data),    32'd0);
        checkOutput("rst_gnt",   32'(bus.gnt_id),     32'd0);
        checkOutput("rst_busy",  32'(bus.busy),       32'd0);
        checkOutput("rst_done",  32'(bus.frame_done), 32'd0);
        rst = 1'b0;

        // No requests: every output must stay at its reset value.
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== '0 ||
                bus.frame_done !== 1'b0 || bus.tx_data !== 8'h00 || bus.gnt_id !== '0)
                quiet = 1'b0;
        end
        checkOutput("idle_quiet", 32'(quiet), 32'd1);

        // Single request from requester 2.
        reqByte[2] = 8'hA5;
        applyStimulus(4'b0100);
        awaitStart("a5", 5, lat);
        checkOutput("a5_latency", 32'(lat), 32'd1);
        checkGrant("a5", 4'b0100);
        applyStimulus(4'b0000);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.frame_done !== 1'b1 && cnt < 300);
        checkOutput("a5_done_at",   32'(cnt),      32'(FRAME - 1));
        checkOutput("a5_busy_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("a5_busy_after", 32'(bus.busy),       32'd0);
        checkOutput("a5_done_pulse", 32'(bus.frame_done), 32'd0);
        checkOutput("a5_data_held",  32'(bus.tx_data),    32'hA5);

        // All four requesters continuously valid: rotation and exact spacing.
        applyStimulus(4'b1111);
        awaitStart("rr4_first", 5, lat);
        checkGrant("rr4", 4'b1111);
        applyStimulus(4'b1111);
        for (int r = 0; r < 4; r++) begin
            awaitStart("rr4", 300, lat);
            checkOutput("rr4_spacing", 32'(lat), 32'(FRAME + 1));
            checkGrant("rr4", 4'b1111);
            applyStimulus(4'b1111);
        end
        applyStimulus(4'b0000);
        awaitIdle("rr4");

        // Requesters 0 and 3 always valid.
        applyStimulus(4'b1001);
        for (int r = 0; r < 4; r++) begin
            awaitStart("pair", 300, lat);
            checkGrant("pair", 4'b1001);
            applyStimulus(4'b1001);
        end
        applyStimulus(4'b0000);
        awaitIdle("pair");

        // Reset in the middle of HOLD with requesters 1 and 2 pending.
        applyStimulus(4'b0010);
        awaitStart("mid", 5, lat);
        checkGrant("mid", 4'b0010);
        applyStimulus(4'b0110);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        modelLast = NREQ - 1;
        @(negedge clk);
        checkOutput("midrst_busy",  32'(bus.busy),     32'd0);
        checkOutput("midrst_start", 32'(bus.tx_start), 32'd0);
        checkOutput("midrst_data",  32'(bus.tx_data),  32'd0);
        rst = 1'b0;
        awaitStart("midrst", 5, lat);
        checkOutput("midrst_latency", 32'(lat), 32'd1);
        checkGrant("midrst", 4'b0110);
        applyStimulus(4'b0000);
        awaitIdle("midrst");

        // Requester 1 raises and drops valid while the block is busy.
        applyStimulus(4'b0100);
        awaitStart("drop", 5, lat);
        checkGrant("drop", 4'b0100);
        applyStimulus(4'b0000);
        repeat (20) @(negedge clk);
        applyStimulus(4'b0010);
        repeat (30) @(negedge clk);
        applyStimulus(4'b0000);
        awaitIdle("drop");
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx_start !== 1'b0 || bus.req_ready !== '0) quiet = 1'b0;
        end
        checkOutput("drop_no_grant", 32'(quiet),       32'd1);
        checkOutput("drop_data",     32'(bus.tx_data), 32'(lastData));

        // Randomized request patterns.
        for (int r = 0; r < 6; r++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) reqByte[i] = 8'($urandom);
            applyStimulus(v);
            awaitStart("rand", 5, lat);
            checkOutput("rand_latency", 32'(lat), 32'd1);
            checkGrant("rand", v);
            applyStimulus(4'b0000);
            awaitIdle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
